// File: rtl/nco_ctrl_pkg.sv
// Shared definitions for the NCO sweep controller: default widths and FSM state encoding.
package nco_ctrl_pkg;

   localparam int unsigned PwDefault = 32;
   localparam int unsigned CwDefault = 16;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StDwell = 2'd1,
      StDone  = 2'd2
   } sweep_state_e;

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// Command and NCO-drive bundle between a sweep requester, the controller and the NCO.
interface nco_sweep_ctrl_if #(
   parameter int unsigned PW = nco_ctrl_pkg::PwDefault,
   parameter int unsigned CW = nco_ctrl_pkg::CwDefault
);

   logic          i_cmd_valid;
   logic          o_cmd_ready;
   logic [PW-2:0] i_start_inc;
   logic [PW-2:0] i_step;
   logic [CW-1:0] i_nsteps;
   logic [CW-1:0] i_dwell;
   logic          i_phase_rst;
   logic          i_hold;
   logic          i_abort;
   logic [PW-2:0] o_increment;
   logic          o_nco_ce;
   logic          o_nco_reset;
   logic          o_busy;
   logic          o_done;

   // Requester side: issues commands, observes the NCO drive and status.
   modport master (
      output i_cmd_valid, i_start_inc, i_step, i_nsteps, i_dwell,
             i_phase_rst, i_hold, i_abort,
      input  o_cmd_ready, o_increment, o_nco_ce, o_nco_reset, o_busy, o_done
   );

   // Controller side.
   modport slave (
      input  i_cmd_valid, i_start_inc, i_step, i_nsteps, i_dwell,
             i_phase_rst, i_hold, i_abort,
      output o_cmd_ready, o_increment, o_nco_ce, o_nco_reset, o_busy, o_done
   );

endinterface

// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency sweep controller: walks an NCO increment from a start value in fixed
// steps, holding each frequency for a programmable dwell, then pulses done.
module nco_sweep_ctrl
   import nco_ctrl_pkg::*;
#(
   parameter int unsigned PW = PwDefault,
   parameter int unsigned CW = CwDefault
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   nco_sweep_ctrl_if.slave  bus
);

   sweep_state_e  state_q;
   logic [PW-2:0] inc_q;
   logic [PW-2:0] step_q;
   logic [CW-1:0] steps_left_q;
   logic [CW-1:0] dwell_cnt_q;
   logic [CW-1:0] dwell_len_q;
   logic          hold_q;
   logic          nco_ce_q;
   logic          nco_rst_q;
   logic          busy_q;
   logic          done_q;

   assign bus.o_cmd_ready = (state_q == StIdle);
   assign bus.o_increment = inc_q;
   assign bus.o_nco_ce    = nco_ce_q;
   assign bus.o_nco_reset = nco_rst_q;
   assign bus.o_busy      = busy_q;
   assign bus.o_done      = done_q;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q      <= StIdle;
         inc_q        <= '0;
         step_q       <= '0;
         steps_left_q <= '0;
         dwell_cnt_q  <= '0;
         dwell_len_q  <= '0;
         hold_q       <= 1'b0;
         nco_ce_q     <= 1'b0;
         nco_rst_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         nco_rst_q <= 1'b0;
         done_q    <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // Abort is meaningless here; only a valid command moves us.
               if (bus.i_cmd_valid) begin
                  state_q      <= StDwell;
                  inc_q        <= bus.i_start_inc;
                  step_q       <= bus.i_step;
                  steps_left_q <= bus.i_nsteps;
                  dwell_cnt_q  <= bus.i_dwell;
                  dwell_len_q  <= bus.i_dwell;
                  hold_q       <= bus.i_hold;
                  nco_rst_q    <= bus.i_phase_rst;
                  nco_ce_q     <= 1'b1;
                  busy_q       <= 1'b1;
               end
            end
            StDwell: begin
               if (bus.i_abort) begin
                  state_q  <= StIdle;
                  nco_ce_q <= 1'b0;
                  busy_q   <= 1'b0;
               end else if (dwell_cnt_q == '0) begin
                  if (steps_left_q != '0) begin
                     inc_q        <= inc_q + step_q;
                     steps_left_q <= steps_left_q - CW'(1);
                     dwell_cnt_q  <= dwell_len_q;
                  end else begin
                     state_q  <= StDone;
                     done_q   <= 1'b1;
                     busy_q   <= 1'b0;
                     nco_ce_q <= hold_q;
                  end
               end else begin
                  dwell_cnt_q <= dwell_cnt_q - CW'(1);
               end
            end
            StDone: begin
               state_q <= StIdle;
               if (bus.i_abort) begin
                  nco_ce_q <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: directed sweeps plus random traffic against a
// frequency-plan reference model.
module tb_nco_sweep_ctrl;
   import nco_ctrl_pkg::*;

   localparam int unsigned PW = PwDefault;
   localparam int unsigned CW = CwDefault;
   localparam int unsigned IW = PW - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   nco_sweep_ctrl_if #(.PW(PW), .CW(CW)) bus ();

   nco_sweep_ctrl #(.PW(PW), .CW(CW)) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", tag, $time, act, exp);
      end
   endtask

   // Reference model: on accept, the whole sweep is expanded into a list of the increment
   // expected on every dwell cycle; outputs then follow that list.
   logic [IW-1:0] plan[$];
   logic [IW-1:0] e_inc   = '0;
   logic          e_ce    = 1'b0;
   logic          e_rst   = 1'b0;
   logic          e_busy  = 1'b0;
   logic          e_done  = 1'b0;
   logic          e_ready = 1'b1;
   logic          m_hold  = 1'b0;

   function automatic void make_plan(input logic [IW-1:0] start, input logic [IW-1:0] step,
                                     input logic [CW-1:0] nsteps, input logic [CW-1:0] dwell);
      logic [IW-1:0] f;
      plan.delete();
      for (int k = 0; k <= int'(nsteps); k++) begin
         f = start + IW'(k) * step;
         for (int d = 0; d <= int'(dwell); d++) plan.push_back(f);
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         plan.delete();
         e_inc   <= '0;
         e_ce    <= 1'b0;
         e_rst   <= 1'b0;
         e_busy  <= 1'b0;
         e_done  <= 1'b0;
         e_ready <= 1'b1;
         m_hold  <= 1'b0;
      end else begin
         e_rst <= 1'b0;
         if (e_ready) begin
            if (bus.i_cmd_valid) begin
               make_plan(bus.i_start_inc, bus.i_step, bus.i_nsteps, bus.i_dwell);
               e_inc   <= plan.pop_front();
               m_hold  <= bus.i_hold;
               e_rst   <= bus.i_phase_rst;
               e_ce    <= 1'b1;
               e_busy  <= 1'b1;
               e_ready <= 1'b0;
            end
         end else if (e_busy) begin
            if (bus.i_abort) begin
               plan.delete();
               e_ce    <= 1'b0;
               e_busy  <= 1'b0;
               e_ready <= 1'b1;
            end else if (plan.size() > 0) begin
               e_inc <= plan.pop_front();
            end else begin
               e_busy <= 1'b0;
               e_done <= 1'b1;
               e_ce   <= m_hold;
            end
         end else if (e_done) begin
            e_done  <= 1'b0;
            e_ready <= 1'b1;
            if (bus.i_abort) e_ce <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      check_eq("ready", bus.o_cmd_ready, e_ready);
      check_eq("inc",   bus.o_increment, e_inc);
      check_eq("ce",    bus.o_nco_ce,    e_ce);
      check_eq("nrst",  bus.o_nco_reset, e_rst);
      check_eq("busy",  bus.o_busy,      e_busy);
      check_eq("done",  bus.o_done,      e_done);
   end

   task automatic idle_inputs();
      bus.i_cmd_valid = 1'b0;
      bus.i_start_inc = '0;
      bus.i_step      = '0;
      bus.i_nsteps    = '0;
      bus.i_dwell     = '0;
      bus.i_phase_rst = 1'b0;
      bus.i_hold      = 1'b0;
      bus.i_abort     = 1'b0;
   endtask

   task automatic set_cmd(input logic [IW-1:0] s, input logic [IW-1:0] st,
                          input logic [CW-1:0] n, input logic [CW-1:0] dw,
                          input logic pr, input logic h);
      bus.i_cmd_valid = 1'b1;
      bus.i_start_inc = s;
      bus.i_step      = st;
      bus.i_nsteps    = n;
      bus.i_dwell     = dw;
      bus.i_phase_rst = pr;
      bus.i_hold      = h;
   endtask

   task automatic wait_ready(input int bound);
      int i = 0;
      while (!bus.o_cmd_ready && i < bound) begin
         @(negedge clk);
         i++;
      end
      check_eq("ready_wait", bus.o_cmd_ready, 1'b1);
   endtask

   // Returns on the negedge following the accepting edge.
   task automatic issue(input logic [IW-1:0] s, input logic [IW-1:0] st,
                        input logic [CW-1:0] n, input logic [CW-1:0] dw,
                        input logic pr, input logic h);
      wait_ready(200);
      set_cmd(s, st, n, dw, pr, h);
      @(negedge clk);
      bus.i_cmd_valid = 1'b0;
   endtask

   int            cyc;
   int            n_pulse;
   int            done_at;
   int            rst_at;
   logic [IW-1:0] neg_step;

   initial begin
      idle_inputs();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic sweep: done expected on the 9th cycle after accept.
      issue(IW'('h100), IW'('h10), CW'(3), CW'(1), 1'b0, 1'b0);
      cyc = 1;
      while (!bus.o_done && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("basic_done_cycle", cyc, 9);
      @(negedge clk);
      check_eq("basic_ready_after", bus.o_cmd_ready, 1'b1);

      // Wrap through 2^(PW-1).
      issue(IW'('h7FFF_FFF0), IW'('h20), CW'(1), CW'(0), 1'b0, 1'b0);
      check_eq("wrap_inc0", bus.o_increment, IW'('h7FFF_FFF0));
      @(negedge clk);
      check_eq("wrap_inc1", bus.o_increment, IW'('h10));
      wait_ready(50);

      // Negative step with hold.
      neg_step = '0 - IW'('h100);
      issue(IW'('h1000), neg_step, CW'(2), CW'(0), 1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      check_eq("neg_inc2", bus.o_increment, IW'('h0E00));
      wait_ready(50);
      repeat (3) @(negedge clk);
      check_eq("hold_ce", bus.o_nco_ce, 1'b1);
      check_eq("hold_inc", bus.o_increment, IW'('h0E00));

      // Abort on the third dwell cycle.
      issue(IW'('h2000), IW'('h1), CW'(4), CW'(3), 1'b1, 1'b1);
      @(negedge clk);
      @(negedge clk);
      bus.i_abort = 1'b1;
      @(negedge clk);
      bus.i_abort = 1'b0;
      check_eq("abort_ce", bus.o_nco_ce, 1'b0);
      check_eq("abort_done", bus.o_done, 1'b0);
      check_eq("abort_ready", bus.o_cmd_ready, 1'b1);
      check_eq("abort_inc_held", bus.o_increment, IW'('h2000));
      repeat (3) @(negedge clk);

      // Reset mid-sweep, then a command on the very first edge after release.
      issue(IW'('h500), IW'('h3), CW'(5), CW'(2), 1'b0, 1'b1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_inc",   bus.o_increment, '0);
      check_eq("rst_ce",    bus.o_nco_ce,    1'b0);
      check_eq("rst_nrst",  bus.o_nco_reset, 1'b0);
      check_eq("rst_busy",  bus.o_busy,      1'b0);
      check_eq("rst_done",  bus.o_done,      1'b0);
      check_eq("rst_ready", bus.o_cmd_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      set_cmd(IW'('h77), IW'('h1), CW'(0), CW'(0), 1'b1, 1'b0);
      @(negedge clk);
      bus.i_cmd_valid = 1'b0;
      check_eq("post_rst_accept", bus.o_busy, 1'b1);
      wait_ready(50);

      // Back-to-back with valid held high.
      set_cmd(IW'('h40), IW'('h4), CW'(1), CW'(1), 1'b1, 1'b0);
      n_pulse = 0;
      done_at = -1;
      rst_at  = -1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (bus.o_nco_reset) begin
            n_pulse++;
            if (n_pulse == 2) rst_at = i;
         end
         if (bus.o_done && done_at < 0) done_at = i;
      end
      bus.i_cmd_valid = 1'b0;
      check_eq("b2b_pulses", n_pulse, 2);
      check_eq("b2b_gap", rst_at - done_at, 2);
      wait_ready(50);

      // Random traffic, including commands and aborts at arbitrary times.
      for (int c = 0; c < 1500; c++) begin
         bus.i_cmd_valid = ($urandom_range(0, 3) == 0);
         bus.i_start_inc = IW'($urandom);
         bus.i_step      = IW'($urandom);
         bus.i_nsteps    = CW'($urandom_range(0, 4));
         bus.i_dwell     = CW'($urandom_range(0, 3));
         bus.i_phase_rst = 1'($urandom_range(0, 1));
         bus.i_hold      = 1'($urandom_range(0, 1));
         bus.i_abort     = ($urandom_range(0, 11) == 0);
         @(negedge clk);
      end
      idle_inputs();
      repeat (40) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
